// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding and default key codes for the alarm keypad FSM
package alarm_pkg;
    typedef enum logic [2:0] {
        SHOW_TIME        = 3'd0,
        KEY_STORED       = 3'd1,
        KEY_WAITED       = 3'd2,
        KEY_ENTRY        = 3'd3,
        SHOW_ALARM       = 3'd4,
        SET_ALARM_TIME   = 3'd5,
        SET_CURRENT_TIME = 3'd6
    } state_t;
    localparam int NOKEY_CODE  = 10;
    localparam int CANCEL_CODE = 11;
endpackage

// File: rtl/entry_timeout_ctr.sv
// entry_timeout_ctr: counts idle seconds during key entry and flags abandonment
module entry_timeout_ctr #(
    parameter int TIMEOUT_S = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic one_second,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_S + 1);
    logic [CW-1:0] count;
    // seconds counter, held at TIMEOUT_S so it can never wrap back to zero
    always_ff @(posedge clock or posedge reset)
        if (reset) count <= '0;
        else if (clear) count <= '0;
        else if (one_second && count != CW'(TIMEOUT_S)) count <= count + CW'(1);
    assign expire = one_second && count == CW'(TIMEOUT_S - 1);
endmodule

// File: rtl/multi_alarm_key_fsm.sv
// multi_alarm_key_fsm: keypad entry controller for a clock with several alarm slots
module multi_alarm_key_fsm
    import alarm_pkg::*;
#(
    parameter int KEY_W      = 4,
    parameter int NOKEY      = NOKEY_CODE,
    parameter int CANCEL_KEY = CANCEL_CODE,
    parameter int DIGITS     = 4,
    parameter int TIMEOUT_S  = 10,
    parameter int NUM_ALARMS = 4,
    parameter int SEL_W      = $clog2(NUM_ALARMS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         one_second,
    input  logic [KEY_W-1:0]             key,
    input  logic                         alarm_button,
    input  logic                         time_button,
    input  logic [SEL_W-1:0]             alarm_sel,
    output logic                         show_new_time,
    output logic                         show_a,
    output logic [SEL_W-1:0]             a_idx,
    output logic [NUM_ALARMS-1:0]        load_new_a,
    output logic                         load_new_c,
    output logic                         reset_count,
    output logic                         shift,
    output logic [$clog2(DIGITS+1)-1:0]  digit_cnt
);
    localparam int DW = $clog2(DIGITS + 1);
    localparam logic [KEY_W-1:0] NK = KEY_W'(NOKEY);
    localparam logic [KEY_W-1:0] CK = KEY_W'(CANCEL_KEY);
    state_t state, next;
    logic   full, idle_key, digit_key, expire, clear, latch;
    assign full      = digit_cnt == DW'(DIGITS);
    assign idle_key  = key == NK;
    assign digit_key = !idle_key && key != CK;
    // count only while waiting on the user; any state change restarts it
    assign clear = next != state || !(state == KEY_WAITED || state == KEY_ENTRY);
    assign latch = next != state && (next == SHOW_ALARM || next == SET_ALARM_TIME);
    entry_timeout_ctr #(.TIMEOUT_S(TIMEOUT_S)) u_timeout (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .one_second (one_second),
        .expire     (expire)
    );
    // state register
    always_ff @(posedge clock or posedge reset)
        if (reset) state <= SHOW_TIME;
        else state <= next;
    // entry digit count and alarm slot latched when an alarm view or load begins
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            digit_cnt <= '0;
            a_idx     <= '0;
        end else begin
            if (next == SHOW_TIME) digit_cnt <= '0;
            else if (state == KEY_STORED && !full) digit_cnt <= digit_cnt + DW'(1);
            if (latch) a_idx <= alarm_sel;
        end
    // next-state selection and Moore output decode
    always_comb begin
        next          = SHOW_TIME;
        show_new_time = 1'b0;
        show_a        = 1'b0;
        load_new_a    = '0;
        load_new_c    = 1'b0;
        reset_count   = 1'b0;
        shift         = 1'b0;
        case (state)
            SHOW_TIME:
                next = alarm_button ? SHOW_ALARM : digit_key ? KEY_STORED : SHOW_TIME;
            KEY_STORED: begin
                next          = KEY_WAITED;
                shift         = 1'b1;
                show_new_time = 1'b1;
            end
            KEY_WAITED: begin
                next          = idle_key ? KEY_ENTRY : expire ? SHOW_TIME : KEY_WAITED;
                show_new_time = 1'b1;
            end
            KEY_ENTRY: begin
                next = (alarm_button && full) ? SET_ALARM_TIME :
                       (time_button && full)  ? SET_CURRENT_TIME :
                       expire                 ? SHOW_TIME :
                       key == CK              ? SHOW_TIME :
                       (!idle_key && !full)   ? KEY_STORED : KEY_ENTRY;
                show_new_time = 1'b1;
            end
            SHOW_ALARM: begin
                next   = alarm_button ? SHOW_ALARM : SHOW_TIME;
                show_a = 1'b1;
            end
            SET_ALARM_TIME:
                load_new_a = NUM_ALARMS'(1) << a_idx;
            SET_CURRENT_TIME: begin
                load_new_c  = 1'b1;
                reset_count = 1'b1;
            end
            default: next = SHOW_TIME;
        endcase
    end
endmodule

// File: tb/tb_multi_alarm_key_fsm.sv
// tb_multi_alarm_key_fsm: directed and random checks against a behavioural keypad model
module tb_multi_alarm_key_fsm;
    localparam int NK = 10;
    localparam int CK = 11;
    localparam int IDLE = 0, ALARM = 1, GOT = 2, HOLD = 3, READY = 4, LOADA = 5, LOADC = 6;

    logic       clock = 1'b0;
    logic       reset;
    logic       one_second = 1'b0;
    logic [3:0] key = 4'd10;
    logic       alarm_button = 1'b0;
    logic       time_button = 1'b0;
    logic [1:0] alarm_sel = 2'd0;
    logic       show_new_time, show_a, load_new_c, reset_count, shift;
    logic [1:0] a_idx;
    logic [3:0] load_new_a;
    logic [2:0] digit_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int n_shift = 0;
    int n_loada = 0;
    int n_loadc = 0;
    int last_loada = 0;

    multi_alarm_key_fsm dut (
        .clock         (clock),
        .reset         (reset),
        .one_second    (one_second),
        .key           (key),
        .alarm_button  (alarm_button),
        .time_button   (time_button),
        .alarm_sel     (alarm_sel),
        .show_new_time (show_new_time),
        .show_a        (show_a),
        .a_idx         (a_idx),
        .load_new_a    (load_new_a),
        .load_new_c    (load_new_c),
        .reset_count   (reset_count),
        .shift         (shift),
        .digit_cnt     (digit_cnt)
    );

    always #5 clock = ~clock;

    // model: phase of the user interaction, digits typed, idle seconds in this phase, chosen slot
    typedef struct packed {
        int phase;
        int digits;
        int idle;
        int slot;
    } mdl_t;
    mdl_t m;

    function automatic mdl_t advance(mdl_t c, int k, bit ab, bit tbn, int sel, bit os);
        mdl_t n = c;
        bit tmo = os && c.idle == 9;
        bit full = c.digits == 4;
        case (c.phase)
            IDLE:  if (ab) begin n.phase = ALARM; n.slot = sel; end
                   else if (k != NK && k != CK) n.phase = GOT;
            ALARM: if (!ab) n.phase = IDLE;
            GOT:   begin n.phase = HOLD; n.digits = full ? 4 : c.digits + 1; end
            HOLD:  if (k == NK) n.phase = READY; else if (tmo) n.phase = IDLE;
            READY: if (ab && full) begin n.phase = LOADA; n.slot = sel; end
                   else if (tbn && full) n.phase = LOADC;
                   else if (tmo || k == CK) n.phase = IDLE;
                   else if (k != NK && !full) n.phase = GOT;
            default: n.phase = IDLE;
        endcase
        if (n.phase != c.phase || !(n.phase == HOLD || n.phase == READY)) n.idle = 0;
        else if (os) n.idle = c.idle + 1;
        if (n.phase == IDLE) n.digits = 0;
        return n;
    endfunction

    always @(posedge clock or posedge reset)
        if (reset) m <= '0;
        else m <= advance(m, int'(key), alarm_button, time_button, int'(alarm_sel), one_second);

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // every cycle: DUT outputs against the model, plus pulse tallies for directed checks
    always @(negedge clock) begin
        check("shift", int'(shift), int'(m.phase == GOT));
        check("show_new_time", int'(show_new_time), int'(m.phase == GOT || m.phase == HOLD || m.phase == READY));
        check("show_a", int'(show_a), int'(m.phase == ALARM));
        check("load_new_a", int'(load_new_a), m.phase == LOADA ? (1 << m.slot) : 0);
        check("load_new_c", int'(load_new_c), int'(m.phase == LOADC));
        check("reset_count", int'(reset_count), int'(m.phase == LOADC));
        check("digit_cnt", int'(digit_cnt), m.digits);
        check("a_idx", int'(a_idx), m.slot);
        if (shift) n_shift++;
        if (load_new_c) n_loadc++;
        if (|load_new_a) begin
            n_loada++;
            last_loada = int'(load_new_a);
        end
    end

    task automatic step(int k, bit ab = 1'b0, bit tbn = 1'b0, int sel = 0, bit os = 1'b0);
        key          = k[3:0];
        alarm_button = ab;
        time_button  = tbn;
        alarm_sel    = sel[1:0];
        one_second   = os;
        @(posedge clock);
        #2;
    endtask

    task automatic digit(int d);
        step(d);
        step(NK);
        step(NK);
    endtask

    task automatic clr_tally();
        n_shift = 0;
        n_loada = 0;
        n_loadc = 0;
        last_loada = 0;
    endtask

    initial begin
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_show_new_time", int'(show_new_time), 0);
        check("rst_digit_cnt", int'(digit_cnt), 0);
        check("rst_load_new_a", int'(load_new_a), 0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        step(NK);

        clr_tally();
        for (int d = 1; d <= 4; d++) digit(d);
        check("r25_digits", int'(digit_cnt), 4);
        check("r25_shifts", n_shift, 4);
        step(NK, 1'b0, 1'b1);
        check("r25_load_c", int'(load_new_c), 1);
        check("r25_reset_count", int'(reset_count), 1);
        step(NK);
        check("r25_back_idle", int'(show_new_time), 0);
        check("r25_digits_clr", int'(digit_cnt), 0);
        check("r25_loadc_count", n_loadc, 1);

        clr_tally();
        for (int d = 5; d <= 8; d++) digit(d);
        step(NK, 1'b1, 1'b1, 2);
        check("r26_load_a", int'(load_new_a), 4);
        check("r26_a_idx", int'(a_idx), 2);
        step(NK);
        check("r26_loada_count", n_loada, 1);
        check("r26_loada_value", last_loada, 4);
        check("r26_no_load_c", n_loadc, 0);

        clr_tally();
        digit(1);
        digit(2);
        repeat (9) step(NK, 1'b0, 1'b0, 0, 1'b1);
        check("r27_before_timeout", int'(show_new_time), 1);
        step(NK, 1'b0, 1'b0, 0, 1'b1);
        check("r27_timed_out", int'(show_new_time), 0);
        check("r27_digits_clr", int'(digit_cnt), 0);
        check("r27_no_load", n_loada + n_loadc, 0);

        step(5);
        step(5);
        repeat (9) step(5, 1'b0, 1'b0, 0, 1'b1);
        check("r28_held", int'(show_new_time), 1);
        step(NK);
        step(NK, 1'b0, 1'b0, 0, 1'b1);
        check("r28_no_timeout", int'(show_new_time), 1);
        check("r28_digits", int'(digit_cnt), 1);
        step(CK);
        check("r28_cancel", int'(show_new_time), 0);
        step(NK);

        clr_tally();
        for (int d = 0; d < 3; d++) digit(d);
        step(CK);
        check("r29_cancel", int'(show_new_time), 0);
        check("r29_digits_clr", int'(digit_cnt), 0);
        check("r29_no_load", n_loada + n_loadc, 0);
        step(NK);
        clr_tally();
        for (int d = 1; d <= 4; d++) digit(d);
        step(6);
        step(NK);
        check("r29_fifth_shifts", n_shift, 4);
        check("r29_fifth_digits", int'(digit_cnt), 4);
        check("r29_still_entry", int'(show_new_time), 1);
        step(CK);
        step(NK);

        digit(3);
        digit(4);
        clr_tally();
        reset = 1'b1;
        #1;
        check("r30_show_new_time", int'(show_new_time), 0);
        check("r30_digits", int'(digit_cnt), 0);
        check("r30_shift", int'(shift), 0);
        step(NK);
        reset = 1'b0;
        step(NK);
        check("r30_after_release", int'(show_new_time), 0);
        check("r30_no_load", n_loada + n_loadc, 0);

        repeat (4000) begin
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                step(NK);
                reset = 1'b0;
            end
            step($urandom_range(0, 1) == 1 ? NK : int'($urandom_range(0, 15)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
